// File: rtl/imem_loader_if.sv
// Stream-in / instruction-memory-write bundle for the boot loader.
// The master side is the boot controller (stream source, start/len);
// the slave side is the loader itself.
interface imem_loader_if #(
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = 6
);
  logic              start;
  logic [ADDR_W:0]   len;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [N-1:0]      wdata;
  logic              busy;
  logic              done;
  logic              cpu_reset;

  modport master (
    output start, len, in_data, in_valid,
    input  in_ready, we, waddr, wdata, busy, done, cpu_reset
  );

  modport slave (
    input  start, len, in_data, in_valid,
    output in_ready, we, waddr, wdata, busy, done, cpu_reset
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader: assembles little-endian 32-bit words from a
// byte stream and writes them to instruction memory from address 0,
// holding the CPU in reset until the requested word count is written.
module imem_loader #(
  parameter int unsigned N      = 32,
  parameter int unsigned ADDR_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  imem_loader_if.slave  bus
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W:0]   r_word_cnt;
  logic [ADDR_W:0]   r_len;
  logic [N-9:0]      r_asm;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [N-1:0]      r_wdata;

  logic [ADDR_W:0]   w_len_clamped;
  logic              w_start_ok;
  logic              w_accept;
  logic              w_last_byte;

  assign w_len_clamped = (bus.len > DEPTH) ? DEPTH : bus.len;
  assign w_start_ok    = bus.start && (r_state != S_LOAD);
  assign w_accept      = bus.in_valid && (r_state == S_LOAD);
  assign w_last_byte   = w_accept && (r_byte_cnt == 2'd3) &&
                         (r_word_cnt == r_len - 1'b1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    w_next        = r_state;
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.cpu_reset = 1'b1;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) w_next = (w_len_clamped == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        if (w_last_byte) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
    if (r_state == S_LOAD) begin
      bus.in_ready = 1'b1;
      bus.busy     = 1'b1;
    end
    if (r_state == S_DONE) begin
      bus.done      = 1'b1;
      bus.cpu_reset = 1'b0;
    end
  end

  // Byte assembly, word counting and memory write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_len      <= '0;
      r_asm      <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start_ok) begin
        r_byte_cnt <= '0;
        r_word_cnt <= '0;
        r_len      <= w_len_clamped;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        case (r_byte_cnt)
          2'd0: r_asm[7:0]   <= bus.in_data;
          2'd1: r_asm[15:8]  <= bus.in_data;
          2'd2: r_asm[23:16] <= bus.in_data;
          default: begin
            r_wdata    <= {bus.in_data, r_asm};
            r_waddr    <= r_word_cnt[ADDR_W-1:0];
            r_we       <= 1'b1;
            r_word_cnt <= r_word_cnt + 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.we    = r_we;
  assign bus.waddr = r_waddr;
  assign bus.wdata = r_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams checked
// against a word-level model of the expected memory writes.
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  imem_loader_if #(.N(32), .ADDR_W(6)) bus ();

  imem_loader #(.N(32), .ADDR_W(6)) dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Observation: byte acceptances (with cycle stamp) and memory writes
  int          cyc = 0;
  int          acc_cnt = 0;
  int          acc_cyc [4096];
  int          wr_n = 0;
  int          wr_addr [512];
  logic [31:0] wr_data [512];
  int          wr_acc  [512];
  int          done_cyc = 0;
  logic        prev_done = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
      acc_cyc[acc_cnt % 4096] <= cyc + 1;
      acc_cnt <= acc_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wr_addr[wr_n % 512] <= int'(bus.waddr);
      wr_data[wr_n % 512] <= bus.wdata;
      wr_acc[wr_n % 512]  <= acc_cnt;
      wr_n <= wr_n + 1;
    end
    if (bus.done === 1'b1 && prev_done !== 1'b1) done_cyc <= cyc;
    prev_done <= bus.done;
  end

  // Stream content for the current load
  logic [7:0] tx[$];

  // Word k of the stream, little-endian
  function automatic logic [31:0] mword(input int k);
    return {tx[4*k+3], tx[4*k+2], tx[4*k+1], tx[4*k]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int l);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.len      = 7'(l);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Present tx[from..to-1]; each cycle valid with probability pct percent
  task automatic send(input int from, input int to, input int pct);
    int i;
    int guard;
    i = from;
    guard = 0;
    while (i < to && guard < 5000) begin
      @(negedge clk);
      if (int'($urandom_range(99)) < pct) begin
        bus.in_valid = 1'b1;
        bus.in_data  = tx[i];
        if (bus.in_ready === 1'b1) i++;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
      end
      guard++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("stream_complete", 64'(i), 64'(to));
  endtask

  task automatic check_writes(input int wbase, input int abase, input int nexp, input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_nwrites"}, 64'(wr_n - wbase), 64'(nexp));
    for (int k = 0; k < nexp && wbase + k < wr_n; k++) begin
      chk($sformatf("%s_waddr%0d", tag, k), 64'(wr_addr[(wbase+k) % 512]), 64'(k));
      chk($sformatf("%s_wdata%0d", tag, k), 64'(wr_data[(wbase+k) % 512]), 64'(mword(k)));
      chk($sformatf("%s_wbyte%0d", tag, k), 64'(wr_acc[(wbase+k) % 512] - abase), 64'(4*(k+1)));
    end
  endtask

  task automatic fill_random(input int nbytes);
    tx.delete();
    for (int i = 0; i < nbytes; i++) tx.push_back(8'($urandom));
  endtask

  initial begin
    int wb;
    int ab;
    int first_cyc;
    logic [31:0] w;

    bus.start    = 1'b0;
    bus.len      = '0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;

    // Reset for 2 cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_we", 64'(bus.we), 64'd0);
    chk("rst_waddr", 64'(bus.waddr), 64'd0);
    chk("rst_wdata", 64'(bus.wdata), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_cpu_reset", 64'(bus.cpu_reset), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Idle robustness: valid bytes in IDLE are not consumed
    wb = wr_n;
    ab = acc_cnt;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hff;
      @(posedge clk);
      #1;
      chk("idle_in_ready", 64'(bus.in_ready), 64'd0);
      chk("idle_we", 64'(bus.we), 64'd0);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("idle_no_write", 64'(wr_n - wb), 64'd0);
    chk("idle_no_accept", 64'(acc_cnt - ab), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_done", 64'(bus.done), 64'd0);

    // len=0 from IDLE: done next cycle, no writes
    wb = wr_n;
    do_start(0);
    chk("len0_done", 64'(bus.done), 64'd1);
    chk("len0_cpu_reset", 64'(bus.cpu_reset), 64'd0);
    chk("len0_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    #1;
    chk("len0_no_write", 64'(wr_n - wb), 64'd0);

    // Full load, continuous stream, 47 words
    tx.delete();
    for (int k = 0; k < 47; k++) begin
      w = (k == 0) ? 32'hf8000001 : (k == 46) ? 32'hb400001f : $urandom;
      tx.push_back(w[7:0]);
      tx.push_back(w[15:8]);
      tx.push_back(w[23:16]);
      tx.push_back(w[31:24]);
    end
    wb = wr_n;
    ab = acc_cnt;
    do_start(47);
    chk("full_start_done", 64'(bus.done), 64'd0);
    chk("full_start_cpu_reset", 64'(bus.cpu_reset), 64'd1);
    chk("full_start_busy", 64'(bus.busy), 64'd1);
    send(0, 188, 100);
    chk("full_final_done", 64'(bus.done), 64'd1);
    chk("full_final_cpu_reset", 64'(bus.cpu_reset), 64'd0);
    chk("full_final_in_ready", 64'(bus.in_ready), 64'd0);
    chk("full_final_we", 64'(bus.we), 64'd1);
    chk("full_final_waddr", 64'(bus.waddr), 64'd46);
    check_writes(wb, ab, 47, "full");
    first_cyc = acc_cyc[ab % 4096];
    chk("full_done_cycles", 64'(done_cyc - first_cyc + 1), 64'd188);

    // Stalled stream, len=2
    tx.delete();
    for (int i = 1; i <= 8; i++) tx.push_back(8'(i * 17));
    wb = wr_n;
    ab = acc_cnt;
    do_start(2);
    send(0, 8, 45);
    check_writes(wb, ab, 2, "stall");
    chk("stall_word0", 64'(mword(0)), 64'h44332211);
    chk("stall_done", 64'(bus.done), 64'd1);

    // len=64: full depth
    fill_random(256);
    wb = wr_n;
    ab = acc_cnt;
    do_start(64);
    send(0, 256, 85);
    chk("len64_last_waddr", 64'(bus.waddr), 64'd63);
    check_writes(wb, ab, 64, "len64");

    // len=100 clamps to 64; extra bytes are refused
    fill_random(256);
    wb = wr_n;
    ab = acc_cnt;
    do_start(100);
    send(0, 256, 100);
    chk("len100_in_ready", 64'(bus.in_ready), 64'd0);
    chk("len100_last_waddr", 64'(bus.waddr), 64'd63);
    check_writes(wb, ab, 64, "len100");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("len100_extra_writes", 64'(wr_n - wb), 64'd64);
    chk("len100_extra_accepts", 64'(acc_cnt - ab), 64'd256);

    // Start pulse mid-LOAD is ignored
    fill_random(12);
    wb = wr_n;
    ab = acc_cnt;
    do_start(3);
    send(0, 5, 100);
    do_start(1);
    chk("ign_busy", 64'(bus.busy), 64'd1);
    chk("ign_waddr", 64'(bus.waddr), 64'd0);
    send(5, 12, 70);
    check_writes(wb, ab, 3, "ign");
    chk("ign_done", 64'(bus.done), 64'd1);

    // Restart from DONE with len=1
    fill_random(4);
    wb = wr_n;
    ab = acc_cnt;
    do_start(1);
    chk("rst_from_done_done", 64'(bus.done), 64'd0);
    chk("rst_from_done_cpu_reset", 64'(bus.cpu_reset), 64'd1);
    send(0, 4, 60);
    check_writes(wb, ab, 1, "restart");

    // Asynchronous reset after 6 bytes of a len=4 load
    fill_random(16);
    do_start(4);
    send(0, 6, 100);
    #2;
    reset_n = 1'b0;
    #1;
    chk("amid_in_ready", 64'(bus.in_ready), 64'd0);
    chk("amid_we", 64'(bus.we), 64'd0);
    chk("amid_busy", 64'(bus.busy), 64'd0);
    chk("amid_cpu_reset", 64'(bus.cpu_reset), 64'd1);
    chk("amid_done", 64'(bus.done), 64'd0);
    chk("amid_waddr", 64'(bus.waddr), 64'd0);
    chk("amid_wdata", 64'(bus.wdata), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    fill_random(4);
    wb = wr_n;
    ab = acc_cnt;
    do_start(1);
    send(0, 4, 100);
    check_writes(wb, ab, 1, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global bound so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
